// File: rtl/async_fifo_pkg.sv
// Shared async FIFO definitions: default address width, pointer width and Gray helpers.
// Used by write_ptr_block and read_ptr_block.
package async_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int PTR_W          = DEF_ADDR_WIDTH + 1;

    // Both helpers work on a zero-extended 32-bit value, so any pointer width up to 32 fits.
    function automatic logic [31:0] bin2gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int s = 1; s < 32; s = s * 2) begin
            r = r ^ (r >> s);
        end
        return r;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at and above it.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/write_ptr_block.sv
// Write-domain pointer and full-flag logic of the async FIFO.
// Define WPTR_ALMOST_FULL_EN to add the registered almost_full output.
module write_ptr_block
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = 2
) (
    input  logic                  w_clk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH:0]   g_rptr_sync,
    output logic [ADDR_WIDTH:0]   g_wptr,
    output logic [ADDR_WIDTH:0]   b_wptr,
    output logic                  full
`ifdef WPTR_ALMOST_FULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    if (ADDR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > (2**ADDR_WIDTH) - 1) begin : g_bad_param
        $error("write_ptr_block: illegal ADDR_WIDTH/AF_THRESH");
    end

    logic          wr_ok;
    logic [PW-1:0] b_next;
    logic [PW-1:0] g_next;
    logic [PW-1:0] g_full_match;

    assign wr_ok  = w_en & ~full;
    assign b_next = b_wptr + {{(PW-1){1'b0}}, wr_ok};
    assign g_next = PW'(bin2gray(32'(b_next)));

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign g_full_match = {~g_rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], g_rptr_sync[ADDR_WIDTH-2:0]};

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_LEVEL = PW'((2**ADDR_WIDTH) - AF_THRESH);

    logic [PW-1:0] b_rsync;
    logic [PW-1:0] fill_next;

    gray2bin #(.W(PW)) u_gray2bin (
        .gray (g_rptr_sync),
        .bin  (b_rsync)
    );

    assign fill_next = b_next - b_rsync;

    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (fill_next >= AF_LEVEL);
        end
    end
`endif

    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            b_wptr <= '0;
            g_wptr <= '0;
            full   <= 1'b0;
        end else begin
            b_wptr <= b_next;
            g_wptr <= g_next;
            full   <= (g_next == g_full_match);
        end
    end

endmodule
